rom_arbiter: RTL

Two-requester controller that shares the 64 KiB instruction ROM between the fetch stage and the load unit (constant/literal reads). It arbitrates round-robin, drives the ROM's single request port, and tracks the one outstanding access. It routes the ROM's 1-cycle response back to the winning requester and captures the ROM's combinational exception at issue. A timeout guard returns an error if the ROM never acknowledges.

---
 rtl/rom_arbiter_pkg.sv | 28 ++
 rtl/rom_arbiter_rr_pick2.sv | 22 ++
 rtl/rom_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared constants and types for the instruction-ROM arbiter.
// Exception codes, width encodings, requester ids and FSM states.
package rom_arbiter_pkg;

    localparam int EXCEPTION_LEN = 4;

    localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK               = 4'd0;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ = 4'd2;

    localparam logic [1:0] MEM_WIDTH_NONE = 2'd0;
    localparam logic [1:0] MEM_WIDTH_BYTE = 2'd1;
    localparam logic [1:0] MEM_WIDTH_HALF = 2'd2;
    localparam logic [1:0] MEM_WIDTH_WORD = 2'd3;

    localparam logic ARB_ID_FETCH = 1'b0;
    localparam logic ARB_ID_LOAD  = 1'b1;

    typedef enum logic {
        ROM_ARB_IDLE = 1'b0,
        ROM_ARB_BUSY = 1'b1
    } rom_arb_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  width;
    } rom_req_t;

endpackage

// File: rtl/rom_arbiter_rr_pick2.sv
// Two-input round-robin picker: a lone request wins outright,
// a tie goes to the requester that did not win last time.
module rr_pick2
    import rom_arbiter_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       any_o
);

    always_comb begin
        any_o   = |valid_i;
        grant_o = ARB_ID_FETCH;
        if (&valid_i) begin
            grant_o = ~last_i;
        end else if (valid_i[ARB_ID_LOAD]) begin
            grant_o = ARB_ID_LOAD;
        end
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the instruction ROM between fetch and load: round-robin issue,
// one tracked access, 1-cycle response routing and an ack timeout.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [31:0]              fetch_addr_In,
    input  logic [1:0]               fetch_dataWidth_In,
    input  logic                     fetch_valid_In,
    output logic                     fetch_ready_Out,
    output logic [31:0]              fetch_data_Out,
    output logic [EXCEPTION_LEN-1:0] fetch_exception_Out,
    output logic                     fetch_respValid_Out,

    input  logic [31:0]              load_addr_In,
    input  logic [1:0]               load_dataWidth_In,
    input  logic                     load_valid_In,
    output logic                     load_ready_Out,
    output logic [31:0]              load_data_Out,
    output logic [EXCEPTION_LEN-1:0] load_exception_Out,
    output logic                     load_respValid_Out,

    output logic [31:0]              rom_addr_Out,
    output logic [1:0]               rom_dataWidth_Out,
    output logic                     rom_inputValid_Out,
    input  logic [31:0]              rom_data_In,
    input  logic                     rom_operationOK_In,
    input  logic [EXCEPTION_LEN-1:0] rom_exception_In
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    rom_arb_state_e           state_q, state_d;
    logic                     grant_q, grant_d;
    logic                     last_q, last_d;
    logic [EXCEPTION_LEN-1:0] exc_q, exc_d;
    logic [TW-1:0]            tcnt_q, tcnt_d;

    logic                     win;
    logic                     any;
    logic                     busy;
    logic                     issue_win;
    logic                     issue;
    logic                     resp;
    logic                     tout;
    rom_req_t                 sel;
    logic                     rsp_any;
    logic [31:0]              rsp_data;
    logic [EXCEPTION_LEN-1:0] rsp_exc;

    rr_pick2 u_pick (
        .valid_i ({load_valid_In, fetch_valid_In}),
        .last_i  (last_q),
        .grant_o (win),
        .any_o   (any)
    );

    // Everything below is gated by rst so outputs drop as soon as it falls.
    always_comb begin
        busy      = (state_q == ROM_ARB_BUSY);
        issue_win = !busy || rom_operationOK_In;
        issue     = rst && issue_win && any;
        resp      = rst && busy && rom_operationOK_In;
        tout      = rst && busy && !rom_operationOK_In && (tcnt_q == TLAST);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        exc_d   = exc_q;
        tcnt_d  = tcnt_q;
        if (busy) begin
            if (rom_operationOK_In) begin
                state_d = ROM_ARB_IDLE;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
                if (tout) begin
                    state_d = ROM_ARB_IDLE;
                end
            end
        end
        if (issue) begin
            state_d = ROM_ARB_BUSY;
            grant_d = win;
            last_d  = win;
            exc_d   = rom_exception_In;
            tcnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ROM_ARB_IDLE;
            grant_q <= ARB_ID_FETCH;
            last_q  <= ARB_ID_LOAD;
            exc_q   <= EXCEP_OK;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            exc_q   <= exc_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        sel.addr  = fetch_addr_In;
        sel.width = fetch_dataWidth_In;
        if (win == ARB_ID_LOAD) begin
            sel.addr  = load_addr_In;
            sel.width = load_dataWidth_In;
        end
        rom_inputValid_Out = issue;
        rom_addr_Out       = issue ? sel.addr : '0;
        rom_dataWidth_Out  = issue ? sel.width : '0;
        fetch_ready_Out    = issue && (win == ARB_ID_FETCH);
        load_ready_Out     = issue && (win == ARB_ID_LOAD);
    end

    // A faulted access never exposes ROM data to the requester.
    always_comb begin
        rsp_any  = resp || tout;
        rsp_data = '0;
        rsp_exc  = EXCEP_OK;
        if (resp) begin
            rsp_exc = exc_q;
            if (exc_q == EXCEP_OK) begin
                rsp_data = rom_data_In;
            end
        end else if (tout) begin
            rsp_exc = EXCEP_INVALID_MEM_READ;
        end
    end

    always_comb begin
        fetch_respValid_Out = 1'b0;
        fetch_data_Out      = '0;
        fetch_exception_Out = EXCEP_OK;
        load_respValid_Out  = 1'b0;
        load_data_Out       = '0;
        load_exception_Out  = EXCEP_OK;
        if (rsp_any) begin
            if (grant_q == ARB_ID_LOAD) begin
                load_respValid_Out  = 1'b1;
                load_data_Out       = rsp_data;
                load_exception_Out  = rsp_exc;
            end else begin
                fetch_respValid_Out = 1'b1;
                fetch_data_Out      = rsp_data;
                fetch_exception_Out = rsp_exc;
            end
        end
    end

endmodule
